// File: rtl/text_mode_renderer.sv
// Text-mode pixel pipeline: position -> character cell -> text RAM -> font ROM -> colour index.
// Five-cycle fixed latency on colour, de and both syncs, with a blinking underline cursor.
module text_mode_renderer #(
  parameter int   h_pixels     = 800,
  parameter int   char_w       = 8,
  parameter int   char_h       = 16,
  parameter int   cols         = 100,
  parameter int   rows         = 37,
  parameter int   blink_frames = 30,
  parameter logic h_pol        = 1'b1,
  parameter logic v_pol        = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] h_pos,
  input  logic [31:0] v_pos,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [6:0]  cursor_col,
  input  logic [5:0]  cursor_row,
  input  logic        cursor_en,
  output logic [11:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  color,
  output logic        de,
  output logic        h_sync,
  output logic        v_sync
);

  localparam int               CW_SH      = $clog2(char_w);
  localparam int               CH_SH      = $clog2(char_h);
  localparam logic [31:0]      H_LIM      = 32'(h_pixels);
  localparam logic [31:0]      V_LIM      = 32'(rows * char_h);
  localparam logic [31:0]      COLS_U     = 32'(cols);
  localparam logic [31:0]      ROWS_U     = 32'(rows);
  localparam logic [11:0]      ADDR_COLS  = 12'(cols);
  localparam logic [CH_SH-1:0] CUR_LINE0  = CH_SH'(char_h - 2);
  localparam logic [CW_SH-1:0] PX_MAX     = CW_SH'(char_w - 1);
  localparam logic [5:0]       BLINK_LAST = 6'(blink_frames - 1);

  // Side-band stage index k holds the value registered at edge E(k+1).
  logic [11:0]            text_addr_q, text_addr_d;
  logic [11:0]            font_addr_q, font_addr_d;
  logic [3:0][CW_SH-1:0]  px_q, px_d;
  logic [1:0][CH_SH-1:0]  line_q, line_d;
  logic [3:0]             vld_pipe_q, vld_pipe_d;
  logic [3:0]             hit_q, hit_d;
  logic [1:0][3:0]        fg_q, fg_d;
  logic [1:0][3:0]        bg_q, bg_d;
  logic [3:0]             color_q, color_d;
  logic                   de_q, de_d;
  logic [4:0]             hs_sr_q, hs_sr_d;
  logic [4:0]             vs_sr_q, vs_sr_d;
  logic [5:0]             frame_cnt_q, frame_cnt_d;
  logic                   blink_on_q, blink_on_d;

  logic [31:0] row_w, col_w;
  logic        active, frame_start, cur_cell, cur_hit, pix;

  always_comb begin
    row_w       = v_pos >> CH_SH;
    col_w       = h_pos >> CW_SH;
    active      = (h_pos < H_LIM) && (v_pos < V_LIM) && en;
    frame_start = (h_pos == 32'd0) && (v_pos == 32'd0);
    // Out-of-range cursor positions must never match.
    cur_cell    = cursor_en && blink_on_q &&
                  ({25'd0, cursor_col} < COLS_U) && ({26'd0, cursor_row} < ROWS_U) &&
                  (col_w == {25'd0, cursor_col}) && (row_w == {26'd0, cursor_row});
    cur_hit     = active && cur_cell && (v_pos[CH_SH-1:0] >= CUR_LINE0);

    // E1: address and side-band capture
    text_addr_d   = active ? (row_w[11:0] * ADDR_COLS) + col_w[11:0] : 12'd0;
    px_d[0]       = h_pos[CW_SH-1:0];
    line_d[0]     = v_pos[CH_SH-1:0];
    vld_pipe_d[0] = active;
    hit_d[0]      = cur_hit;

    // E2: text RAM data in flight
    px_d[1]       = px_q[0];
    line_d[1]     = line_q[0];
    vld_pipe_d[1] = vld_pipe_q[0];
    hit_d[1]      = hit_q[0];

    // E3: glyph row fetch, attributes captured
    font_addr_d   = {text_data[7:0], line_q[1]};
    fg_d[0]       = text_data[11:8];
    bg_d[0]       = text_data[15:12];
    px_d[2]       = px_q[1];
    vld_pipe_d[2] = vld_pipe_q[1];
    hit_d[2]      = hit_q[1];

    // E4: font ROM data in flight
    fg_d[1]       = fg_q[0];
    bg_d[1]       = bg_q[0];
    px_d[3]       = px_q[2];
    vld_pipe_d[3] = vld_pipe_q[2];
    hit_d[3]      = hit_q[2];

    // E5: pixel select, cursor inverts the glyph bit
    pix     = font_data[PX_MAX - px_q[3]] ^ hit_q[3];
    color_d = 4'd0;
    de_d    = 1'b0;
    if (vld_pipe_q[3]) begin
      color_d = pix ? fg_q[1] : bg_q[1];
      de_d    = 1'b1;
    end

    hs_sr_d = {hs_sr_q[3:0], h_sync_in};
    vs_sr_d = {vs_sr_q[3:0], v_sync_in};

    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_start) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d = 6'd0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      text_addr_q <= '0;
      font_addr_q <= '0;
      px_q        <= '0;
      line_q      <= '0;
      vld_pipe_q  <= '0;
      hit_q       <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      color_q     <= '0;
      de_q        <= 1'b0;
      hs_sr_q     <= {5{~h_pol}};
      vs_sr_q     <= {5{~v_pol}};
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      px_q        <= px_d;
      line_q      <= line_d;
      vld_pipe_q  <= vld_pipe_d;
      hit_q       <= hit_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      color_q     <= color_d;
      de_q        <= de_d;
      hs_sr_q     <= hs_sr_d;
      vs_sr_q     <= vs_sr_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_addr = font_addr_q;
  assign color     = color_q;
  assign de        = de_q;
  assign h_sync    = hs_sr_q[4];
  assign v_sync    = vs_sr_q[4];

endmodule

// File: tb/tb_text_mode_renderer.sv
// Bench for text_mode_renderer: behavioural memories plus a per-pixel reference model
// whose expectations are queued at drive time and compared five cycles later.
module tb_text_mode_renderer;

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [31:0] h_pos = '0, v_pos = '0;
  logic        h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [5:0]  cursor_row = '0;
  logic        cursor_en = 1'b0;
  logic [11:0] text_addr, font_addr;
  logic [15:0] text_data;
  logic [7:0]  font_data;
  logic [3:0]  color;
  logic        de, h_sync, v_sync;

  always #5 pixel_clk = ~pixel_clk;

  text_mode_renderer dut (
    .pixel_clk (pixel_clk), .reset (reset), .en (en),
    .h_pos (h_pos), .v_pos (v_pos), .h_sync_in (h_sync_in), .v_sync_in (v_sync_in),
    .cursor_col (cursor_col), .cursor_row (cursor_row), .cursor_en (cursor_en),
    .text_addr (text_addr), .text_data (text_data),
    .font_addr (font_addr), .font_data (font_data),
    .color (color), .de (de), .h_sync (h_sync), .v_sync (v_sync)
  );

  logic [15:0] tram [0:4095];
  logic [7:0]  from [0:4095];

  always @(posedge pixel_clk) begin
    text_data <= tram[text_addr];
    font_data <= from[font_addr];
  end

  typedef struct {
    int         due;
    logic [3:0] color;
    logic       de;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t sb [$];
  exp_t me;
  int   checks = 0, errors = 0, cyc = 0;
  int   m_cnt = 0;
  logic m_blink = 1'b1;
  logic ov_en = 1'b0;
  logic [3:0] ov_color = '0;

  always @(posedge pixel_clk) cyc <= cyc + 1;

  always @(negedge pixel_clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      checks++;
      if (me.due != cyc || color !== me.color || de !== me.de || h_sync !== me.hs || v_sync !== me.vs) begin
        errors++;
        $display("FAIL sb_out cyc=%0d due=%0d: got color=%h de=%b hs=%b vs=%b, want color=%h de=%b hs=%b vs=%b",
                 cyc, me.due, color, de, h_sync, v_sync, me.color, me.de, me.hs, me.vs);
      end
    end
  end

  // Drive one pixel just after an edge, queue its expected output, advance to the next edge.
  task automatic step(input int h, input int v, input logic hs, input logic vs);
    exp_t e;
    int col, row, line, px;
    logic act, hit, pix;
    logic [15:0] td;
    logic [7:0] fd;
    logic [3:0] ln4;
    h_pos = h; v_pos = v; h_sync_in = hs; v_sync_in = vs;
    e.due = cyc + 5; e.color = 4'd0; e.de = 1'b0; e.hs = hs; e.vs = vs;
    if (reset) begin
      e.hs = 1'b0; e.vs = 1'b0;
      m_cnt = 0; m_blink = 1'b1;
    end else begin
      col = h / 8; row = v / 16; line = v % 16; px = h % 8;
      act = (h < 800) && (v < 592) && en;
      hit = cursor_en && m_blink && (col == cursor_col) && (row == cursor_row) &&
            (cursor_col < 100) && (cursor_row < 37) && (line >= 14);
      if (act) begin
        ln4 = line[3:0];
        td = tram[row * 100 + col];
        fd = from[{td[7:0], ln4}];
        pix = fd[7 - px] ^ hit;
        e.color = pix ? td[11:8] : td[15:12];
        e.de = 1'b1;
      end
      if (ov_en) begin e.color = ov_color; e.de = 1'b1; end
      if (h == 0 && v == 0) begin
        if (m_cnt == 29) begin m_cnt = 0; m_blink = ~m_blink; end
        else m_cnt++;
      end
    end
    sb.push_back(e);
    @(posedge pixel_clk); #1;
  endtask

  task automatic test_reset();
    h_sync_in = 1'b1; v_sync_in = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    checks++; if (color !== 4'd0)      begin errors++; $display("FAIL rst_color got=%h want=0", color); end
    checks++; if (de !== 1'b0)         begin errors++; $display("FAIL rst_de got=%b want=0", de); end
    checks++; if (h_sync !== 1'b0)     begin errors++; $display("FAIL rst_hs got=%b want=0", h_sync); end
    checks++; if (v_sync !== 1'b0)     begin errors++; $display("FAIL rst_vs got=%b want=0", v_sync); end
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL rst_taddr got=%0d want=0", text_addr); end
    checks++; if (font_addr !== 12'd0) begin errors++; $display("FAIL rst_faddr got=%h want=0", font_addr); end
    step(0, 0, 1'b1, 1'b1);
    step(0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_first_pixel();
    logic [3:0] want [8] = '{4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'h1, 4'h1, 4'h1};
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ov_en = 1'b1; ov_color = want[i];
      step(i, 0, 1'b0, 1'b0);
    end
    ov_en = 1'b0;
    for (int i = 8; i < 24; i++) step(i, 0, 1'b0, 1'b0);
  endtask

  task automatic test_addr();
    step(15, 35, 1'b0, 1'b0);
    checks++; if (text_addr !== 12'd201) begin errors++; $display("FAIL taddr_e1 got=%0d want=201", text_addr); end
    step(15, 35, 1'b0, 1'b0);
    step(15, 35, 1'b0, 1'b0);
    checks++; if (font_addr !== 12'h423) begin errors++; $display("FAIL faddr_e3 got=%h want=423", font_addr); end
    step(800, 35, 1'b0, 1'b0);
    checks++; if (text_addr !== 12'd0) begin errors++; $display("FAIL taddr_off got=%0d want=0", text_addr); end
    step(799, 591, 1'b0, 1'b0);
    checks++; if (text_addr !== 12'd3699) begin errors++; $display("FAIL taddr_last got=%0d want=3699", text_addr); end
  endtask

  task automatic test_sync();
    for (int h = 100; h < 116; h++) step(h, 40, h == 105, h >= 110 && h < 112);
    for (int v = 590; v < 600; v++) step(100, v, 1'b0, v == 595);
  endtask

  task automatic cursor_pass();
    for (int v = 29; v < 32; v++)
      for (int h = 16; h < 24; h++) step(h, v, 1'b0, 1'b0);
  endtask

  task automatic test_cursor();
    cursor_col = 7'd2; cursor_row = 6'd1; cursor_en = 1'b1;
    cursor_pass();
    repeat (30) step(0, 0, 1'b0, 1'b0);
    cursor_pass();
    repeat (30) step(0, 0, 1'b0, 1'b0);
    cursor_pass();
    cursor_col = 7'd100;
    for (int h = 792; h < 808; h++) step(h, 30, 1'b0, 1'b0);
    cursor_col = 7'd2;
  endtask

  task automatic test_reset_mid();
    for (int h = 16; h < 24; h++) step(h, 31, 1'b1, 1'b1);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    checks++; if (color !== 4'd0) begin errors++; $display("FAIL mid_color got=%h want=0", color); end
    checks++; if (de !== 1'b0)    begin errors++; $display("FAIL mid_de got=%b want=0", de); end
    checks++; if (h_sync !== 1'b0) begin errors++; $display("FAIL mid_hs got=%b want=0", h_sync); end
    checks++; if (v_sync !== 1'b0) begin errors++; $display("FAIL mid_vs got=%b want=0", v_sync); end
    @(posedge pixel_clk); #1;
    step(16, 31, 1'b1, 1'b1);
    step(17, 31, 1'b1, 1'b1);
    reset = 1'b0;
    for (int h = 16; h < 32; h++) step(h, 31, h == 20, 1'b0);
  endtask

  task automatic test_en_off();
    en = 1'b0;
    for (int h = 0; h < 820; h++) step(h, 50, h >= 810 && h < 816, 1'b0);
    en = 1'b1;
    for (int h = 0; h < 8; h++) step(h, 50, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'($urandom);
      from[i] = 8'($urandom);
    end
    tram[0]   = 16'h1F41;
    from[12'h410] = 8'h18;
    tram[201] = 16'h5A42;
    tram[102] = 16'h3C55;
    from[12'h55D] = 8'hAA;
    from[12'h55E] = 8'hF0;
    from[12'h55F] = 8'h0F;

    test_reset();
    test_first_pixel();
    test_addr();
    test_sync();
    test_cursor();
    test_reset_mid();
    test_en_off();
    repeat (7) @(posedge pixel_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
